// File: rtl/fetch_unit_pkg.sv
// Shared fetch/controller definitions: opcode field, fetch state encoding, width defaults.
package fetch_unit_pkg;

  localparam int FU_DATA_W = 8;
  localparam int FU_ADDR_W = 13;

  localparam logic [2:0] OPC_LDI = 3'b000;

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_DI   = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // Only the opcode field IR[3:1] decides the instruction length.
  function automatic logic is_two_word(input logic [3:0] op_lo);
    return op_lo[3:1] == OPC_LDI;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/IR/DI ownership, 1-/2-word fetch over req/ack, redirect handling.
// Optional FETCH_TIMEOUT_EN adds a sticky ack-timeout that stalls the stage until a jump.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DATA_W  = FU_DATA_W,
  parameter int ADDR_W  = FU_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] di,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              req_q, req_d;
  logic              disc_q, disc_d;
  logic              stall;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;
  assign stall     = stall_q;
  assign fetch_err = err_q;
`else
  assign stall     = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instr_valid = (state_q == S_HOLD) && !stall;
  assign ir          = ir_q;
  assign di          = di_q;
  assign pc_next     = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    di_d    = di_q;
    req_d   = req_q;
    disc_d  = disc_q;
    unique case (state_q)
      S_OP, S_DI: begin
        if (req_q) begin
          if (mem_ack) begin
            req_d  = 1'b0;
            disc_d = 1'b0;
            if (jump_en) begin
              pc_d    = jump_addr;
              state_d = S_OP;
            end else if (!disc_q) begin
              pc_d = pc_q + ADDR_W'(1);
              if (state_q == S_OP) begin
                ir_d = mem_rdata;
                if (is_two_word(mem_rdata[3:0])) begin
                  state_d = S_DI;
                end else begin
                  di_d    = '0;
                  state_d = S_HOLD;
                end
              end else begin
                di_d    = mem_rdata;
                state_d = S_HOLD;
              end
            end
          end else if (jump_en) begin
            // Request must complete on its old address; its data is dropped on arrival.
            disc_d  = 1'b1;
            pc_d    = jump_addr;
            state_d = S_OP;
          end
        end else if (jump_en) begin
          pc_d    = jump_addr;
          state_d = S_OP;
        end else begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end
      end
      S_HOLD: begin
        if (jump_en) begin
          pc_d    = jump_addr;
          state_d = S_OP;
        end else if (instr_valid && instr_ready) begin
          state_d = S_OP;
        end
      end
      default: state_d = S_OP;
    endcase

`ifdef FETCH_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
    stall_d = stall_q;
    if (!req_q)        tmo_d = '0;
    else if (!mem_ack) tmo_d = tmo_q + TMO_W'(1);
    if (req_q && !mem_ack && !jump_en && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
      err_d   = 1'b1;
      req_d   = 1'b0;
      disc_d  = 1'b0;
      stall_d = 1'b1;
      state_d = S_HOLD;
    end
    if (jump_en) stall_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_OP;
      pc_q    <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      di_q    <= '0;
      req_q   <= 1'b0;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      di_q    <= di_d;
      req_q   <= req_d;
      disc_q  <= disc_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_q   <= '0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table of fetches plus hand sequences for redirects/reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  ir;
  logic [7:0]  di;
  logic [12:0] pc_next;
  logic        jump_en;
  logic [12:0] jump_addr;
  logic        fetch_err;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .ir(ir), .di(di), .pc_next(pc_next),
    .jump_en(jump_en), .jump_addr(jump_addr), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:8191];
  int  lat      = 1;
  bit  mem_en   = 1'b1;
  int  wcnt     = 0;
  int  addr_viol = 0;
  bit  prev_req = 1'b0;
  logic [12:0] prev_addr = '0;
  int  n_total = 0;
  int  n_pass  = 0;

  // Memory answers after 'lat' cycles of request; updates settle 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (prev_req && mem_req && (mem_addr != prev_addr)) addr_viol++;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    if (!rst || !mem_req || mem_ack) begin
      wcnt    = 0;
      mem_ack = 1'b0;
    end else begin
      wcnt++;
      if (mem_en && wcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_jump(input logic [12:0] a);
    jump_addr = a;
    jump_en   = 1'b1;
    step();
    jump_en   = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!instr_valid && n < 60) begin step(); n++; end
    chk(nm, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic wait_req(input string nm, input logic [12:0] a);
    int n = 0;
    while (!(mem_req && mem_addr == a) && n < 60) begin step(); n++; end
    chk(nm, {31'd0, mem_req && (mem_addr == a)}, 32'd1);
  endtask

  // After a redirect: no instruction may appear before the request at tgt, then tgt's word shows up.
  task automatic expect_redirect(input string nm, input logic [12:0] tgt, input logic [7:0] exp_ir);
    int n = 0;
    bit stale = 1'b0;
    logic [12:0] pn;
    while (!(mem_req && mem_addr == tgt) && n < 60) begin
      if (instr_valid) stale = 1'b1;
      step(); n++;
    end
    chk({nm, "_no_stale"}, {31'd0, stale}, 32'd0);
    chk({nm, "_req"}, {31'd0, mem_req && (mem_addr == tgt)}, 32'd1);
    wait_valid({nm, "_valid"});
    pn = tgt + 13'd1;
    chk({nm, "_ir"}, {24'd0, ir}, {24'd0, exp_ir});
    chk({nm, "_pcn"}, {19'd0, pc_next}, {19'd0, pn});
  endtask

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          lat;
    logic [7:0]  e_ir;
    logic [7:0]  e_di;
    logic [12:0] e_pcn;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [12:0] a1;
    logic [7:0]  s_ir, s_di;
    logic [12:0] s_pcn;
    bit          moved;
    int          rc;

    vecs[0] = '{13'h0010, 8'h12, 8'hEE, 1, 8'h12, 8'h00, 13'h0011};
    vecs[1] = '{13'h0004, 8'h01, 8'hA5, 3, 8'h01, 8'hA5, 13'h0006};
    vecs[2] = '{13'h1FFF, 8'h3E, 8'hEE, 2, 8'h3E, 8'h00, 13'h0000};
    vecs[3] = '{13'h1FFF, 8'h00, 8'h77, 1, 8'h00, 8'h77, 13'h0001};
    vecs[4] = '{13'h0ABC, 8'hF1, 8'h5A, 1, 8'hF1, 8'h5A, 13'h0ABE};
    vecs[5] = '{13'h0200, 8'hFF, 8'h11, 4, 8'hFF, 8'h00, 13'h0201};

    for (int i = 0; i < 8192; i++) mem[i] = 8'hEE;
    rst = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset state and first fetch
    mem[0] = 8'h12;
    repeat (3) step();
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_ir", {24'd0, ir}, 32'd0);
    chk("rst_di", {24'd0, di}, 32'd0);
    chk("rst_pcn", {19'd0, pc_next}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    rst = 1'b1;
    step();
    chk("first_req", {31'd0, mem_req && (mem_addr == 13'd0)}, 32'd1);
    wait_valid("first_valid");
    chk("first_ir", {24'd0, ir}, 32'h12);
    chk("first_di", {24'd0, di}, 32'h00);
    chk("first_pcn", {19'd0, pc_next}, 32'd1);

    // Vector table: redirect from HOLD, fetch, compare the presented instruction
    foreach (vecs[i]) begin
      a1 = vecs[i].addr + 13'd1;
      mem[vecs[i].addr] = vecs[i].w0;
      mem[a1] = vecs[i].w1;
      lat = vecs[i].lat;
      pulse_jump(vecs[i].addr);
      wait_req($sformatf("v%0d_req", i), vecs[i].addr);
      wait_valid($sformatf("v%0d_valid", i));
      chk($sformatf("v%0d_ir", i), {24'd0, ir}, {24'd0, vecs[i].e_ir});
      chk($sformatf("v%0d_di", i), {24'd0, di}, {24'd0, vecs[i].e_di});
      chk($sformatf("v%0d_pcn", i), {19'd0, pc_next}, {19'd0, vecs[i].e_pcn});
    end

    // Two-word instruction held stable under backpressure, then consumed
    mem[4] = 8'h01; mem[5] = 8'hA5; mem[6] = 8'h2E; lat = 3;
    pulse_jump(13'h0004);
    wait_valid("hold_valid");
    s_ir = ir; s_di = di; s_pcn = pc_next; moved = 1'b0;
    chk("hold_ir", {24'd0, s_ir}, 32'h01);
    for (int c = 0; c < 5; c++) begin
      step();
      if (!instr_valid || mem_req || ir != s_ir || di != s_di || pc_next != s_pcn) moved = 1'b1;
    end
    chk("hold_stable", {31'd0, moved}, 32'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("accept_drop", {31'd0, instr_valid}, 32'd0);
    wait_req("accept_next_req", 13'h0006);

    // 13'h1FFF one-word fetch wraps: next request after acceptance goes to 0
    wait_valid("pre_wrap_valid");
    mem[13'h1FFF] = 8'h3E; lat = 1;
    pulse_jump(13'h1FFF);
    wait_valid("wrap_valid");
    chk("wrap_pcn", {19'd0, pc_next}, 32'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    wait_req("wrap_next_req", 13'h0000);
    wait_valid("wrap_done");

    // Jump while a fetch at 2 is still pending: stale ack dropped
    mem[2] = 8'h12; mem[13'h100] = 8'h2E; lat = 6;
    pulse_jump(13'h0002);
    wait_req("pend_req", 13'h0002);
    step();
    pulse_jump(13'h0100);
    chk("pend_addr_held", {31'd0, mem_req && (mem_addr == 13'h0002)}, 32'd1);
    expect_redirect("pend", 13'h0100, 8'h2E);

    // Jump coinciding with the ack
    mem[13'h40] = 8'h12; mem[13'h180] = 8'h9E; lat = 2;
    pulse_jump(13'h0040);
    rc = 0;
    while (!mem_ack && rc < 40) begin step(); rc++; end
    chk("ackjmp_ack_seen", {31'd0, mem_ack}, 32'd1);
    pulse_jump(13'h0180);
    expect_redirect("ackjmp", 13'h0180, 8'h9E);

    // Reset in the middle of the operand fetch
    mem[0] = 8'h12; lat = 3;
    pulse_jump(13'h0004);
    wait_req("mid_di_req", 13'h0005);
    rst = 1'b0;
    step();
    chk("mrst_req", {31'd0, mem_req}, 32'd0);
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mrst_ir", {24'd0, ir}, 32'd0);
    chk("mrst_di", {24'd0, di}, 32'd0);
    chk("mrst_pcn", {19'd0, pc_next}, 32'd0);
    rst = 1'b1;
    wait_req("mrst_restart", 13'h0000);
    wait_valid("mrst_valid2");
    chk("mrst_ir2", {24'd0, ir}, 32'h12);

`ifdef FETCH_TIMEOUT_EN
    mem_en = 1'b0;
    pulse_jump(13'h0300);
    rc = 0;
    while (!fetch_err && rc < 40) begin
      if (mem_req) rc++;
      step();
    end
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_cycles", rc, 32'd15);
    chk("tmo_req", {31'd0, mem_req}, 32'd0);
    chk("tmo_valid", {31'd0, instr_valid}, 32'd0);
    mem_en = 1'b1; lat = 1;
    pulse_jump(13'h0000);
    wait_valid("tmo_resume");
    chk("tmo_resume_ir", {24'd0, ir}, 32'h12);
    chk("tmo_sticky", {31'd0, fetch_err}, 32'd1);
`else
    chk("no_tmo_err", {31'd0, fetch_err}, 32'd0);
`endif

    chk("addr_stable", addr_viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
